// File: rtl/mmio_store_ctrl_if.sv
// Stage-3 MMIO store/side-effect bus: address/data/op qualifiers in, UART strobes, status and counters out.
interface mmio_store_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic                 is_store;
  logic                 is_load;
  logic                 s3_valid;
  logic                 instr_retire;
  logic                 uart_tx_ready;
  logic                 uart_rx_valid;
  logic [7:0]           uart_tx_data_in;
  logic                 uart_tx_data_in_valid;
  logic                 uart_rx_data_out_ready;
  logic                 tx_buf_ready;
  logic [CNT_WIDTH-1:0] cyc_counter;
  logic [CNT_WIDTH-1:0] instr_counter;

  modport master (
    output addr, wdata, is_store, is_load, s3_valid, instr_retire,
           uart_tx_ready, uart_rx_valid,
    input  uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready,
           tx_buf_ready, cyc_counter, instr_counter
  );

  modport slave (
    input  addr, wdata, is_store, is_load, s3_valid, instr_retire,
           uart_tx_ready, uart_rx_valid,
    output uart_tx_data_in, uart_tx_data_in_valid, uart_rx_data_out_ready,
           tx_buf_ready, cyc_counter, instr_counter
  );
endinterface

// File: rtl/mmio_store_ctrl.sv
// Store-side MMIO: one-byte UART TX buffer (2-state FSM, 1-cycle store-to-valid), RX pop strobe,
// cycle/retired-instruction counters with store-triggered clear.
module mmio_store_ctrl #(
  parameter logic [31:0] IO_BASE   = 32'h8000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  mmio_store_ctrl_if.slave bus
);

  localparam logic [31:0] ADDR_RX  = IO_BASE + 32'h0000_0004;
  localparam logic [31:0] ADDR_TX  = IO_BASE + 32'h0000_0008;
  localparam logic [31:0] ADDR_CLR = IO_BASE + 32'h0000_0018;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    TX_IDLE,
    TX_FULL
  } tx_state_t;

  tx_state_t            tx_state;
  logic [7:0]           tx_buf;
  logic                 tx_rdy_q;
  logic                 tx_vld_q;
  logic [CNT_WIDTH-1:0] cyc_q;
  logic [CNT_WIDTH-1:0] instr_q;

  logic hit_rx;
  logic hit_tx;
  logic hit_clr;
  logic tx_store;
  logic cnt_clr;
  logic unused_wdata;

  // Full 32-bit compares: IO registers must not alias elsewhere in the map.
  assign hit_rx  = bus.s3_valid && (bus.addr == ADDR_RX);
  assign hit_tx  = bus.s3_valid && (bus.addr == ADDR_TX);
  assign hit_clr = bus.s3_valid && (bus.addr == ADDR_CLR);

  assign tx_store = bus.is_store && hit_tx;
  assign cnt_clr  = bus.is_store && hit_clr;

  assign unused_wdata = ^bus.wdata[31:8];

  assign bus.uart_rx_data_out_ready = !rst && bus.is_load && hit_rx && bus.uart_rx_valid;

  // Buffer only loads in IDLE, so data_in stays stable for the whole FULL period.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_buf   <= 8'h00;
      tx_rdy_q <= 1'b1;
      tx_vld_q <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_store) begin
            tx_buf   <= bus.wdata[7:0];
            tx_state <= TX_FULL;
            tx_rdy_q <= 1'b0;
            tx_vld_q <= 1'b1;
          end
        end
        TX_FULL: begin
          if (bus.uart_tx_ready) begin
            tx_state <= TX_IDLE;
            tx_rdy_q <= 1'b1;
            tx_vld_q <= 1'b0;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_rdy_q <= 1'b1;
          tx_vld_q <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over the increment in the same cycle; counting resumes on the following edge.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_ONE;
      if (bus.instr_retire) begin
        instr_q <= instr_q + CNT_ONE;
      end
    end
  end

  assign bus.uart_tx_data_in       = tx_buf;
  assign bus.uart_tx_data_in_valid = tx_vld_q;
  assign bus.tx_buf_ready          = tx_rdy_q;
  assign bus.cyc_counter           = cyc_q;
  assign bus.instr_counter         = instr_q;

endmodule
